// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status from ID/EX/MEM towards the controller,
// plus the stall/flush strobes, status flags and counters coming back.
interface pipe_hazard_ctrl_if;
  logic        i_id_valid;
  logic [4:0]  i_id_rs1;
  logic [4:0]  i_id_rs2;
  logic        i_id_use_rs1;
  logic        i_id_use_rs2;
  logic        i_ex_valid;
  logic [4:0]  i_ex_rd;
  logic        i_ex_mem_read;
  logic        i_ex_mispred;
  logic        i_mem_req;
  logic        i_mem_ready;
  logic        o_stall_if;
  logic        o_stall_id;
  logic        o_stall_mem;
  logic        o_stall_wb;
  logic        o_flush_id;
  logic        o_flush_ex;
  logic        o_redirect;
  logic        o_mem_timeout;
  logic [1:0]  o_state;
  logic [31:0] o_stall_cnt;
  logic [31:0] o_flush_cnt;

  modport master (
    output i_id_valid, i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
    output i_ex_valid, i_ex_rd, i_ex_mem_read, i_ex_mispred, i_mem_req, i_mem_ready,
    input  o_stall_if, o_stall_id, o_stall_mem, o_stall_wb, o_flush_id, o_flush_ex,
    input  o_redirect, o_mem_timeout, o_state, o_stall_cnt, o_flush_cnt
  );

  modport slave (
    input  i_id_valid, i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
    input  i_ex_valid, i_ex_rd, i_ex_mem_read, i_ex_mispred, i_mem_req, i_mem_ready,
    output o_stall_if, o_stall_id, o_stall_mem, o_stall_wb, o_flush_id, o_flush_ex,
    output o_redirect, o_mem_timeout, o_state, o_stall_cnt, o_flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller for the 5-stage pipeline: memory-wait stall, mispredict
// redirect/flush sequencing, load-use bubble, DMEM timeout flag and perf counters.
module pipe_hazard_ctrl #(
  parameter int unsigned REDIRECT_FLUSH = 1,
  parameter int unsigned MEM_TIMEOUT    = 256
) (
  input logic               i_clk,
  input logic               i_reset,
  pipe_hazard_ctrl_if.slave hz
);
  localparam logic [2:0]  RF_L = 3'(REDIRECT_FLUSH);
  localparam logic [15:0] MT_L = 16'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [2:0]  redir_cnt_reg, redir_cnt_next;
  logic [15:0] wait_cnt_reg, wait_cnt_next;
  logic        timeout_reg, timeout_next;
  logic [31:0] stall_cnt_reg, stall_cnt_next;
  logic [31:0] flush_cnt_reg, flush_cnt_next;

  logic mem_wait, mispredict, load_use, in_redirect;
  logic stall_if, stall_rest, flush_id, flush_ex, redirect;

  assign mem_wait    = hz.i_mem_req && !hz.i_mem_ready;
  assign mispredict  = hz.i_ex_mispred && hz.i_ex_valid;
  assign in_redirect = (state_reg == ST_REDIRECT);
  assign load_use    = hz.i_ex_valid && hz.i_ex_mem_read && (hz.i_ex_rd != 5'd0) && hz.i_id_valid &&
                       ((hz.i_id_use_rs1 && (hz.i_id_rs1 == hz.i_ex_rd)) ||
                        (hz.i_id_use_rs2 && (hz.i_id_rs2 == hz.i_ex_rd)));

  // Strobes: mem wait beats mispredict beats load-use; all quiet while in reset.
  always_comb begin
    stall_if   = 1'b0;
    stall_rest = 1'b0;
    flush_id   = 1'b0;
    flush_ex   = 1'b0;
    redirect   = 1'b0;
    if (i_reset) begin
      flush_id = in_redirect;
      if (mem_wait) begin
        stall_if   = 1'b1;
        stall_rest = 1'b1;
      end else if (mispredict) begin
        flush_id = 1'b1;
        flush_ex = 1'b1;
        redirect = 1'b1;
      end else if (load_use && !in_redirect) begin
        stall_if = 1'b1;
        flush_ex = 1'b1;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    redir_cnt_next = redir_cnt_reg;
    wait_cnt_next  = wait_cnt_reg;
    timeout_next   = timeout_reg;
    case (state_reg)
      ST_RUN, ST_MEM_WAIT: begin
        if (mem_wait) begin
          state_next = ST_MEM_WAIT;
          if (state_reg == ST_RUN)
            wait_cnt_next = 16'd1;
          else if (wait_cnt_reg < MT_L)
            wait_cnt_next = wait_cnt_reg + 16'd1;
        end else begin
          // Exiting MEM_WAIT behaves exactly like a RUN cycle.
          wait_cnt_next = 16'd0;
          state_next    = ST_RUN;
          if (mispredict && (RF_L != 3'd0)) begin
            state_next     = ST_REDIRECT;
            redir_cnt_next = RF_L;
          end
        end
      end
      ST_REDIRECT: begin
        if (!mem_wait) begin
          if (mispredict)
            redir_cnt_next = RF_L;
          else if (redir_cnt_reg <= 3'd1) begin
            redir_cnt_next = 3'd0;
            state_next     = ST_RUN;
          end else
            redir_cnt_next = redir_cnt_reg - 3'd1;
        end
      end
      default: state_next = ST_RUN;
    endcase
    if (wait_cnt_next == MT_L)
      timeout_next = 1'b1;
  end

  assign stall_cnt_next = (stall_if && (stall_cnt_reg != 32'hFFFF_FFFF)) ? stall_cnt_reg + 32'd1 : stall_cnt_reg;
  assign flush_cnt_next = (redirect && (flush_cnt_reg != 32'hFFFF_FFFF)) ? flush_cnt_reg + 32'd1 : flush_cnt_reg;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_reg     <= ST_RUN;
      redir_cnt_reg <= 3'd0;
      wait_cnt_reg  <= 16'd0;
      timeout_reg   <= 1'b0;
      stall_cnt_reg <= 32'd0;
      flush_cnt_reg <= 32'd0;
    end else begin
      state_reg     <= state_next;
      redir_cnt_reg <= redir_cnt_next;
      wait_cnt_reg  <= wait_cnt_next;
      timeout_reg   <= timeout_next;
      stall_cnt_reg <= stall_cnt_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  assign hz.o_stall_if    = stall_if;
  assign hz.o_stall_id    = stall_rest;
  assign hz.o_stall_mem   = stall_rest;
  assign hz.o_stall_wb    = stall_rest;
  assign hz.o_flush_id    = flush_id;
  assign hz.o_flush_ex    = flush_ex;
  assign hz.o_redirect    = redirect;
  assign hz.o_mem_timeout = timeout_reg;
  assign hz.o_state       = state_reg;
  assign hz.o_stall_cnt   = stall_cnt_reg;
  assign hz.o_flush_cnt   = flush_cnt_reg;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (REDIRECT_FLUSH=2, MEM_TIMEOUT=4): directed
// cycles push hand-computed expectations; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(.REDIRECT_FLUSH(2), .MEM_TIMEOUT(4)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .hz      (bus)
  );

  typedef struct {
    string       nm;
    logic [6:0]  strb;  // {stall_if, stall_id, stall_mem, stall_wb, flush_id, flush_ex, redirect}
    logic [1:0]  st;
    logic        to;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [6:0] S0  = 7'b0000000;
  localparam logic [6:0] LU  = 7'b1000010;
  localparam logic [6:0] MW  = 7'b1111000;
  localparam logic [6:0] MP  = 7'b0000111;
  localparam logic [6:0] FI  = 7'b0000100;
  localparam logic [6:0] MWF = 7'b1111100;

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      logic [6:0] act;
      e   = sb_q.pop_front();
      act = {bus.o_stall_if, bus.o_stall_id, bus.o_stall_mem, bus.o_stall_wb,
             bus.o_flush_id, bus.o_flush_ex, bus.o_redirect};
      n_tests++;
      if (act !== e.strb || bus.o_state !== e.st || bus.o_mem_timeout !== e.to ||
          bus.o_stall_cnt !== e.sc || bus.o_flush_cnt !== e.fc) begin
        n_fail++;
        $display("[TB] FAIL %s: got strb=%b st=%0d to=%b sc=%0d fc=%0d, want strb=%b st=%0d to=%b sc=%0d fc=%0d",
                 e.nm, act, bus.o_state, bus.o_mem_timeout, bus.o_stall_cnt, bus.o_flush_cnt,
                 e.strb, e.st, e.to, e.sc, e.fc);
      end else begin
        $display("[TB] ok   %s: strb=%b st=%0d to=%b sc=%0d fc=%0d",
                 e.nm, act, bus.o_state, bus.o_mem_timeout, bus.o_stall_cnt, bus.o_flush_cnt);
      end
    end
  end

  task automatic drv(input logic mreq, input logic mrdy, input logic mp, input logic exv,
                     input logic ld, input logic [4:0] rd, input logic idv,
                     input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2);
    bus.i_mem_req     = mreq;
    bus.i_mem_ready   = mrdy;
    bus.i_ex_mispred  = mp;
    bus.i_ex_valid    = exv;
    bus.i_ex_mem_read = ld;
    bus.i_ex_rd       = rd;
    bus.i_id_valid    = idv;
    bus.i_id_rs1      = r1;
    bus.i_id_use_rs1  = u1;
    bus.i_id_rs2      = r2;
    bus.i_id_use_rs2  = u2;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  // One cycle: queue the expectation for the current inputs, then advance past the edge.
  task automatic exp(input string nm, input logic [6:0] strb, input logic [1:0] st,
                     input logic to, input int unsigned sc, input int unsigned fc);
    exp_t e;
    e.nm = nm; e.strb = strb; e.st = st; e.to = to; e.sc = sc; e.fc = fc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    exp("reset", S0, 2'd0, 1'b0, 0, 0);
    rst_n = 1'b1;
    exp("idle", S0, 2'd0, 1'b0, 0, 0);

    // Load-use detection
    drv(0, 0, 0, 1, 1, 5'd5, 1, 5'd3, 1, 5'd5, 1); exp("lu_rs2", LU, 2'd0, 1'b0, 0, 0);
    idle();                                        exp("lu_one", S0, 2'd0, 1'b0, 1, 0);
    drv(0, 0, 0, 1, 1, 5'd0, 1, 5'd0, 1, 5'd0, 1); exp("lu_x0", S0, 2'd0, 1'b0, 1, 0);
    drv(0, 0, 0, 1, 1, 5'd7, 1, 5'd3, 1, 5'd7, 0); exp("lu_nouse", S0, 2'd0, 1'b0, 1, 0);
    drv(0, 0, 0, 1, 1, 5'd9, 1, 5'd9, 1, 5'd4, 1); exp("lu_rs1", LU, 2'd0, 1'b0, 1, 0);
    drv(0, 0, 0, 1, 1, 5'd9, 0, 5'd9, 1, 5'd4, 1); exp("lu_idinv", S0, 2'd0, 1'b0, 2, 0);
    drv(0, 0, 0, 1, 0, 5'd9, 1, 5'd9, 1, 5'd0, 0); exp("lu_noload", S0, 2'd0, 1'b0, 2, 0);

    // Memory wait, three cycles then ready
    drv(1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0);
    exp("mw0", MW, 2'd0, 1'b0, 2, 0);
    exp("mw1", MW, 2'd1, 1'b0, 3, 0);
    exp("mw2", MW, 2'd1, 1'b0, 4, 0);
    bus.i_mem_ready = 1'b1; exp("mw_rdy", S0, 2'd1, 1'b0, 5, 0);
    idle();                 exp("mw_run", S0, 2'd0, 1'b0, 5, 0);

    // Mispredict with two trailing IF/ID flush cycles
    drv(0, 0, 1, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0); exp("mp", MP, 2'd0, 1'b0, 5, 0);
    idle();
    exp("mp_f1", FI, 2'd2, 1'b0, 5, 1);
    exp("mp_f2", FI, 2'd2, 1'b0, 5, 1);
    exp("mp_run", S0, 2'd0, 1'b0, 5, 1);

    // Mispredict beats load-use; REDIRECT behaviour
    drv(0, 0, 1, 1, 1, 5'd5, 1, 5'd5, 1, 5'd0, 0); exp("mp_lu", MP, 2'd0, 1'b0, 5, 1);
    drv(0, 0, 0, 1, 1, 5'd5, 1, 5'd5, 1, 5'd0, 0); exp("rd_lu_sup", FI, 2'd2, 1'b0, 5, 2);
    drv(0, 0, 1, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0); exp("rd_mp", MP, 2'd2, 1'b0, 5, 2);
    drv(1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0); exp("rd_mw", MWF, 2'd2, 1'b0, 5, 3);
    drv(1, 0, 1, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0); exp("rd_mw_mp", MWF, 2'd2, 1'b0, 6, 3);
    bus.i_mem_ready = 1'b1;                         exp("rd_rdy_mp", MP, 2'd2, 1'b0, 7, 3);
    idle();
    exp("rd_f1", FI, 2'd2, 1'b0, 7, 4);
    exp("rd_f2", FI, 2'd2, 1'b0, 7, 4);
    exp("rd_run", S0, 2'd0, 1'b0, 7, 4);

    // Mispredict held during a memory wait, serviced on the ready cycle
    drv(1, 0, 1, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0);
    exp("mwmp0", MW, 2'd0, 1'b0, 7, 4);
    exp("mwmp1", MW, 2'd1, 1'b0, 8, 4);
    bus.i_mem_ready = 1'b1; exp("mwmp_rdy", MP, 2'd1, 1'b0, 9, 4);
    idle();
    exp("mwmp_f1", FI, 2'd2, 1'b0, 9, 5);
    exp("mwmp_f2", FI, 2'd2, 1'b0, 9, 5);
    exp("mwmp_run", S0, 2'd0, 1'b0, 9, 5);

    // Timeout after four wait cycles, sticky afterwards
    drv(1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0);
    exp("to1", MW, 2'd0, 1'b0, 9, 5);
    exp("to2", MW, 2'd1, 1'b0, 10, 5);
    exp("to3", MW, 2'd1, 1'b0, 11, 5);
    exp("to4", MW, 2'd1, 1'b0, 12, 5);
    exp("to5", MW, 2'd1, 1'b1, 13, 5);
    exp("to6", MW, 2'd1, 1'b1, 14, 5);
    bus.i_mem_ready = 1'b1; exp("to_rdy", S0, 2'd1, 1'b1, 15, 5);
    idle();                 exp("to_sticky", S0, 2'd0, 1'b1, 15, 5);

    // Asynchronous reset in the middle of a memory wait
    drv(1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0);
    exp("rw0", MW, 2'd0, 1'b1, 15, 5);
    exp("rw1", MW, 2'd1, 1'b1, 16, 5);
    rst_n = 1'b0;
    exp("rst_async", S0, 2'd0, 1'b0, 0, 0);
    rst_n = 1'b1;
    exp("post_rst_mw", MW, 2'd0, 1'b0, 0, 0);
    exp("post_rst_mw2", MW, 2'd1, 1'b0, 1, 0);
    bus.i_mem_ready = 1'b1; exp("post_rdy", S0, 2'd1, 1'b0, 2, 0);
    idle();                 exp("end", S0, 2'd0, 1'b0, 2, 0);

    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard controller for the 5-stage pipeline.
- Generates per-register stall and flush strobes for IF/ID, ID/EX, EX/MEM and MEM/WB.
- Resolves three hazards: data-memory wait, EX-stage branch mispredict, and load-use.
- Sequences multi-cycle redirect flushes, flags data-memory timeouts, and keeps saturating performance counters.

Parameters:
REDIRECT_FLUSH, 1, extra cycles IF/ID is flushed after a mispredict (covers IMEM latency); legal range 0..7
MEM_TIMEOUT, 256, max consecutive MEM_WAIT cycles before the timeout error; legal range 2..65535

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous active-low reset
i_id_valid  in  1  ID stage holds a valid, non-bubble instruction
i_id_rs1  in  5  ID source register 1
i_id_rs2  in  5  ID source register 2
i_id_use_rs1  in  1  ID instruction reads rs1
i_id_use_rs2  in  1  ID instruction reads rs2
i_ex_valid  in  1  EX holds a valid, non-bubble instruction
i_ex_rd  in  5  EX destination register
i_ex_mem_read  in  1  EX instruction is a load
i_ex_mispred  in  1  EX branch/jump resolved mispredicted
i_mem_req  in  1  EX/MEM output is a valid load or store
i_mem_ready  in  1  data memory completes the access this cycle
o_stall_if  out  1  hold PC and IF/ID
o_stall_id  out  1  hold ID/EX
o_stall_mem  out  1  hold EX/MEM
o_stall_wb  out  1  hold MEM/WB
o_flush_id  out  1  bubble into IF/ID
o_flush_ex  out  1  bubble into ID/EX
o_redirect  out  1  one-cycle pulse: PC loads the EX redirect target
o_mem_timeout  out  1  sticky error flag
o_state  out  2  0=RUN, 1=MEM_WAIT, 2=REDIRECT
o_stall_cnt  out  32  saturating count of cycles with o_stall_if=1
o_flush_cnt  out  32  saturating count of o_redirect pulses

Behaviour:
- Reset, asynchronous while i_reset=0:
  - state=RUN; redirect counter=0; wait counter=0; o_mem_timeout=0; both perf counters=0.
  - All combinational strobes forced to 0 while i_reset=0.
- Strobes are combinational from the current state and inputs, valid the same cycle. State and counters update on the rising edge.
- Priority 1, mem_wait = i_mem_req && !i_mem_ready:
  - o_stall_if, o_stall_id, o_stall_mem, o_stall_wb = 1.
  - No flush, no redirect.
  - Mispredict and load-use are ignored; their sources are held, so they re-evaluate after the wait.
- Priority 2, mispredict = i_ex_mispred && i_ex_valid, when not mem_wait:
  - o_flush_id=1, o_flush_ex=1, o_redirect=1, all stalls 0.
  - The branch itself advances into EX/MEM.
- Priority 3, load_use = i_ex_valid && i_ex_mem_read && i_ex_rd!=0 && i_id_valid && ((i_id_use_rs1 && rs1==rd) || (i_id_use_rs2 && rs2==rd)), when neither of the above:
  - o_stall_if=1, o_flush_ex=1.
  - Exactly one bubble, because the load leaves EX on the next edge.
- State RUN:
  - If mem_wait → MEM_WAIT, wait counter=1.
  - Else if mispredict and REDIRECT_FLUSH>0 → REDIRECT, redirect counter=REDIRECT_FLUSH.
  - Otherwise stay in RUN.
- State MEM_WAIT:
  - Strobes as for mem_wait while mem_wait holds.
  - Wait counter increments and saturates at MEM_TIMEOUT.
  - When the counter reaches MEM_TIMEOUT, set o_mem_timeout; it stays set until reset.
  - When i_mem_ready=1, the stall drops that same cycle. Next state is RUN, with the counter cleared.
  - A mispredict present on the exit cycle is serviced that cycle and takes the normal RUN→REDIRECT path.
- State REDIRECT:
  - o_flush_id=1 every cycle; redirect counter decrements each cycle; at 1 → RUN.
  - mem_wait in REDIRECT stalls as above. Flush stays asserted, the counter does not decrement, and the state is held.
  - A new mispredict in REDIRECT pulses o_redirect and o_flush_ex, and reloads the counter to REDIRECT_FLUSH.
  - Load-use detection is suppressed in REDIRECT, since ID is invalid.
- Perf counters:
  - o_stall_cnt +1 on every edge with o_stall_if=1.
  - o_flush_cnt +1 per o_redirect.
  - Both saturate at 32'hFFFF_FFFF and never wrap.
- x0 is never a hazard. i_id_use_* = 0 suppresses matching on that source.

Test Plan:
- Reset with i_reset=0 mid-MEM_WAIT (wait counter=5) → o_state=0 immediately, all strobes 0, counters 0, o_mem_timeout=0.
- EX load to x5 (i_ex_rd=5, i_ex_mem_read=1), ID reads rs2=5 with use_rs2=1 → o_stall_if=1, o_flush_ex=1 for exactly 1 cycle; o_stall_cnt=1. Repeat with rd=0 → no stall.
- i_mem_req=1, i_mem_ready=0 for 3 cycles, then 1 → all four stalls high 3 cycles, low on the ready cycle; o_state 1,1,1 then 0; o_stall_cnt=3.
- Mispredict with REDIRECT_FLUSH=2 → cycle0 o_redirect=1, o_flush_id=1, o_flush_ex=1; cycles 1–2 o_flush_id=1 only, o_state=2; cycle3 RUN; o_flush_cnt=1.
- Mispredict and load-use in the same cycle → redirect/flush asserted, o_stall_if=0; mispredict during mem_wait → no redirect until i_mem_ready=1.
- MEM_TIMEOUT=4, i_mem_ready held 0 for 6 cycles → o_mem_timeout rises after the 4th wait cycle and stays 1 after ready returns.
